lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
Memory-access stage directly downstream of the execute ALU in the RV32I pipeline. It consumes the ALU result as a load/store effective address, or as a pass-through result for non-memory ops. It drives a request/grant/response data-memory bus and performs byte-lane steering, write strobes and load sign/zero extension. It hands one result per instruction to writeback.

Parameters:
TIMEOUT_CYC, 255, cycles to wait for dmem_rvalid_i after grant before flagging a bus error (1..255).

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous reset, active-high
ex_valid_i  in  1  execute presents an instruction
ex_ready_o  out  1  stage can accept (high only in IDLE)
ex_result_i  in  32  ALU result: effective address for loads/stores, writeback data otherwise
ex_wdata_i  in  32  store data (rs2)
ex_funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
ex_is_load_i  in  1  load instruction
ex_is_store_i  in  1  store instruction
ex_rd_i  in  5  destination register
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 = write
dmem_be_o  out  4  byte enables
dmem_addr_o  out  32  word-aligned address (bits 1:0 = 0)
dmem_wdata_o  out  32  lane-steered store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  response (loads and stores)
dmem_rdata_i  in  32  read word
wb_valid_o  out  1  one-cycle retire pulse
wb_we_o  out  1  register-file write enable
wb_rd_o  out  5  destination register
wb_data_o  out  32  writeback data
misalign_o  out  1  one-cycle pulse with wb_valid_o: misaligned access
bus_err_o  out  1  one-cycle pulse with wb_valid_o: response timeout

Behaviour:
- Reset: state IDLE; all outputs 0 except ex_ready_o = 1; timeout counter 0. Reset mid-transaction abandons it with no writeback; dmem_req_o drops asynchronously.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE: accept when ex_valid_i & ex_ready_o.
  - Non-memory op: next cycle wb_valid_o=1, wb_we_o=(rd!=0), wb_data_o=ex_result_i; stays IDLE. Latency 1.
  - Load/store: latch address, funct3, rd, type and steered data; go to REQ.
- REQ: dmem_req_o=1 with stable addr/we/be/wdata until dmem_gnt_i; on grant go to WAIT_RSP and clear the counter. Grant in the first REQ cycle is legal.
- WAIT_RSP: dmem_req_o=0.
  - On dmem_rvalid_i: wb_valid_o=1 next cycle.
    - Load: wb_we_o=(rd!=0), extracted data.
    - Store: wb_we_o=0.
    - Return to IDLE.
  - Counter increments each cycle without rvalid. When it reaches TIMEOUT_CYC: bus_err_o=1, wb_valid_o=1, wb_we_o=0, go to IDLE. rvalid on the same cycle as the limit wins; no error.
- rvalid outside WAIT_RSP is ignored.
- Byte enables from addr[1:0]: B = 0001<<a; H = 0011<<a; W = 1111.
- Store data steering: B replicates byte ×4; H replicates halfword ×2.
- Load extraction: byte = rdata[8a+7:8a]; halfword = rdata[16a[1]+15:16a[1]]. B/H sign-extend; BU/HU zero-extend.
- ex_is_load_i & ex_is_store_i both high: treated as load.
- Invalid funct3 on a memory op: treated as W.

Optional Feature:
- Macro LSU_MISALIGN_EXC_EN.
- Defined: H with a[0]=1 or W with a[1:0]!=0 issues no bus request. Next cycle wb_valid_o=1, misalign_o=1, wb_we_o=0; stays IDLE.
- Undefined: misalign_o is tied 0; low address bits are masked to the natural alignment (H: a[0]=0, W: a=00) and the access proceeds normally.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 load/store width constants;
  - the FSM state enum;
  - functions calc_be(funct3, a) and steer_wdata(funct3, wdata).
- Natural sub-module: lsu_load_align. Combinational extraction plus sign/zero extension from rdata, addr[1:0] and funct3.

Test Plan:
- Non-memory op, result 0x0000_1234, rd=5 -> next cycle wb_valid_o=1, wb_we_o=1, wb_data_o=0x0000_1234, no dmem_req_o.
- LB at 0x0000_0101, grant after 2 cycles, rdata 0x1234_80FF -> dmem_addr_o=0x100, be=0010, wb_data_o=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH at 0x0000_0102, wdata 0x0000_ABCD -> dmem_we_o=1, be=1100, dmem_wdata_o=0xABCD_ABCD; after rvalid, wb_valid_o=1, wb_we_o=0.
- LW at 0x0000_0103 with LSU_MISALIGN_EXC_EN -> no request, misalign_o=1 with wb_valid_o. Without the macro -> request at 0x100, be=1111.
- TIMEOUT_CYC=4, grant but no rvalid -> bus_err_o=1 four cycles after grant, ex_ready_o=1 next cycle. rvalid on cycle 4 -> normal writeback, no error.
- Assert rst_i during WAIT_RSP -> outputs return to reset values immediately; a late rvalid is ignored; no wb_valid_o.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, funct3 width codes and byte-lane helpers for
//               the RV32I load/store stage.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // funct3 access-width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stage FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } lsu_state_e;

  // Map any unsupported funct3 to a full-word access. Stores have no
  // unsigned variants, so BU/HU are only legal on loads.
  function automatic logic [2:0] norm_funct3(input logic [2:0] f3,
                                             input logic       is_load);
    logic [2:0] res;
    res = F3_W;
    case (f3)
      F3_B, F3_H, F3_W: res = f3;
      F3_BU, F3_HU:     res = is_load ? f3 : F3_W;
      default:          res = F3_W;
    endcase
    return res;
  endfunction

  // Force the low address bits to the natural alignment of the access
  function automatic logic [1:0] align_addr(input logic [2:0] f3,
                                            input logic [1:0] a);
    logic [1:0] res;
    case (f3[1:0])
      2'b00:   res = a;
      2'b01:   res = {a[1], 1'b0};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  // True when the access is not naturally aligned
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] a);
    logic res;
    case (f3[1:0])
      2'b00:   res = 1'b0;
      2'b01:   res = a[0];
      default: res = (a != 2'b00);
    endcase
    return res;
  endfunction

  // Byte enables for the access width at byte offset a
  function automatic logic [3:0] calc_be(input logic [2:0] f3,
                                         input logic [1:0] a);
    logic [3:0] res;
    case (f3[1:0])
      2'b00:   res = 4'b0001 << a;
      2'b01:   res = 4'b0011 << a;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  // Replicate narrow store data across every lane so the byte enables alone
  // select the destination bytes
  function automatic logic [31:0] steer_wdata(input logic [2:0]  f3,
                                              input logic [31:0] wdata);
    logic [31:0] res;
    case (f3[1:0])
      2'b00:   res = {4{wdata[7:0]}};
      2'b01:   res = {2{wdata[15:0]}};
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Extracts the addressed byte/halfword from a read word and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select and extension
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule : lsu_load_align
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage
// Description : RV32I memory-access stage. Issues loads/stores on a
//               request/grant/response bus, steers byte lanes, extends load
//               data and retires one writeback per instruction. Non-memory
//               ops pass through with one cycle of latency.
//               Optional macro LSU_MISALIGN_EXC_EN: misaligned H/W accesses
//               retire immediately with misalign_o instead of being aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] ex_result_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic        ex_is_load_i,
  input  logic        ex_is_store_i,
  input  logic [4:0]  ex_rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e state;
  lsu_state_e state_next;

  logic             accept;
  logic             is_mem;
  logic             misal;
  logic             start_mem;
  logic [2:0]       f3_norm;
  logic [1:0]       addr_lo;
  logic             timeout_hit;
  logic [CNT_W-1:0] wait_cnt;

  logic [31:0] mem_addr;
  logic [1:0]  mem_lo;
  logic [2:0]  mem_f3;
  logic [4:0]  mem_rd;
  logic        mem_load;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] load_data;

  assign accept  = ex_valid_i & ex_ready_o;
  assign is_mem  = ex_is_load_i | ex_is_store_i;
  assign f3_norm = norm_funct3(ex_funct3_i, ex_is_load_i);
  // Aligned accesses are unaffected; misaligned ones either trap (below)
  // or get their low bits masked here.
  assign addr_lo = align_addr(f3_norm, ex_result_i[1:0]);

`ifdef LSU_MISALIGN_EXC_EN
  assign misal = is_mem & is_misaligned(f3_norm, ex_result_i[1:0]);
`else
  assign misal = 1'b0;
`endif

  assign start_mem   = accept & is_mem & ~misal;
  // A response in the limit cycle takes priority over the timeout
  assign timeout_hit = (state == ST_WAIT_RSP) & ~dmem_rvalid_i &
                       (wait_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start_mem) state_next = ST_REQ;
      ST_REQ:      if (dmem_gnt_i) state_next = ST_WAIT_RSP;
      ST_WAIT_RSP: if (dmem_rvalid_i || timeout_hit) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // FSM outputs; decoded from state so reset drops the request at once
  always_comb begin
    ex_ready_o = (state == ST_IDLE);
    dmem_req_o = (state == ST_REQ);
  end

  // Capture the request at issue so it stays stable throughout REQ
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_addr  <= 32'h0;
      mem_lo    <= 2'b00;
      mem_f3    <= 3'b000;
      mem_rd    <= 5'd0;
      mem_load  <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
    end else if (start_mem) begin
      mem_addr  <= {ex_result_i[31:2], 2'b00};
      mem_lo    <= addr_lo;
      mem_f3    <= f3_norm;
      mem_rd    <= ex_rd_i;
      mem_load  <= ex_is_load_i;
      mem_we    <= ~ex_is_load_i;
      mem_be    <= calc_be(f3_norm, addr_lo);
      mem_wdata <= ex_is_load_i ? 32'h0 : steer_wdata(f3_norm, ex_wdata_i);
    end
  end

  assign dmem_addr_o  = mem_addr;
  assign dmem_we_o    = mem_we;
  assign dmem_be_o    = mem_be;
  assign dmem_wdata_o = mem_wdata;

  // Response timeout counter, restarted by each grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (state == ST_REQ && dmem_gnt_i) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT_RSP && !dmem_rvalid_i && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  lsu_load_align u_load_align (
    .rdata   (dmem_rdata_i),
    .addr_lo (mem_lo),
    .funct3  (mem_f3),
    .data    (load_data)
  );

  // Writeback register: single-cycle retire pulse per instruction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_rd_o    <= 5'd0;
      wb_data_o  <= 32'h0;
      bus_err_o  <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      bus_err_o  <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid_o <= 1'b1;
        wb_we_o    <= (ex_rd_i != 5'd0);
        wb_rd_o    <= ex_rd_i;
        wb_data_o  <= ex_result_i;
      end else if (accept && misal) begin
        wb_valid_o <= 1'b1;
        wb_rd_o    <= ex_rd_i;
        wb_data_o  <= 32'h0;
      end else if (state == ST_WAIT_RSP && dmem_rvalid_i) begin
        wb_valid_o <= 1'b1;
        wb_we_o    <= mem_load & (mem_rd != 5'd0);
        wb_rd_o    <= mem_rd;
        wb_data_o  <= mem_load ? load_data : 32'h0;
      end else if (timeout_hit) begin
        wb_valid_o <= 1'b1;
        wb_rd_o    <= mem_rd;
        wb_data_o  <= 32'h0;
        bus_err_o  <= 1'b1;
      end
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic misal_pulse;

  // Misalignment flag accompanies the immediate retire pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) misal_pulse <= 1'b0;
    else       misal_pulse <= accept & misal;
  end

  assign misalign_o = misal_pulse;
`else
  assign misalign_o = 1'b0;
`endif

endmodule : lsu_stage
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_stage
// Description : Directed self-checking bench for lsu_stage (TIMEOUT_CYC=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_result_i;
  logic [31:0] ex_wdata_i;
  logic [2:0]  ex_funct3_i;
  logic        ex_is_load_i;
  logic        ex_is_store_i;
  logic [4:0]  ex_rd_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;
  logic        bus_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  lsu_stage #(.TIMEOUT_CYC(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .ex_result_i   (ex_result_i),
    .ex_wdata_i    (ex_wdata_i),
    .ex_funct3_i   (ex_funct3_i),
    .ex_is_load_i  (ex_is_load_i),
    .ex_is_store_i (ex_is_store_i),
    .ex_rd_i       (ex_rd_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .wb_valid_o    (wb_valid_o),
    .wb_we_o       (wb_we_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .misalign_o    (misalign_o),
    .bus_err_o     (bus_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction for a single cycle; returns at the negedge
  // after the accepting clock edge.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic ld, input logic st,
                       input logic [4:0] rd);
    @(negedge clk_i);
    check("ready_before_issue", ex_ready_o, 1);
    ex_valid_i    = 1'b1;
    ex_result_i   = addr;
    ex_wdata_i    = wdata;
    ex_funct3_i   = f3;
    ex_is_load_i  = ld;
    ex_is_store_i = st;
    ex_rd_i       = rd;
    @(negedge clk_i);
    ex_valid_i    = 1'b0;
  endtask

  // Full bus transaction: gw extra REQ cycles before grant, rw empty
  // WAIT_RSP cycles before the response.
  task automatic mem_op(input string tag, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic ld, input logic st, input logic [4:0] rd,
                        input int gw, input int rw, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_wb,
                        input logic exp_wb_we);
    issue(addr, wdata, f3, ld, st, rd);
    check({tag, ".req"},   dmem_req_o, 1);
    check({tag, ".rdy"},   ex_ready_o, 0);
    check({tag, ".addr"},  dmem_addr_o, exp_addr);
    check({tag, ".be"},    dmem_be_o, exp_be);
    check({tag, ".we"},    dmem_we_o, st & ~ld);
    if (st && !ld) check({tag, ".wdata"}, dmem_wdata_o, exp_wd);
    for (int i = 0; i < gw; i++) begin
      @(negedge clk_i);
      check({tag, ".req_hold"},  dmem_req_o, 1);
      check({tag, ".addr_hold"}, dmem_addr_o, exp_addr);
    end
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    check({tag, ".req_drop"}, dmem_req_o, 0);
    for (int i = 0; i < rw; i++) begin
      @(negedge clk_i);
      check({tag, ".no_wb_yet"}, wb_valid_o, 0);
    end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check({tag, ".wb_valid"}, wb_valid_o, 1);
    check({tag, ".wb_we"},    wb_we_o, exp_wb_we);
    check({tag, ".wb_rd"},    wb_rd_o, rd);
    check({tag, ".bus_err"},  bus_err_o, 0);
    check({tag, ".misalign"}, misalign_o, 0);
    if (ld) check({tag, ".wb_data"}, wb_data_o, exp_wb);
    @(negedge clk_i);
    check({tag, ".wb_pulse"}, wb_valid_o, 0);
    check({tag, ".rdy_back"}, ex_ready_o, 1);
  endtask

  initial begin
    rst_i = 1'b1;
    ex_valid_i = 1'b0; ex_result_i = '0; ex_wdata_i = '0; ex_funct3_i = '0;
    ex_is_load_i = 1'b0; ex_is_store_i = 1'b0; ex_rd_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst.ready",    ex_ready_o, 1);
    check("rst.req",      dmem_req_o, 0);
    check("rst.be",       dmem_be_o, 0);
    check("rst.addr",     dmem_addr_o, 0);
    check("rst.wb_valid", wb_valid_o, 0);
    check("rst.wb_data",  wb_data_o, 0);
    check("rst.bus_err",  bus_err_o, 0);
    check("rst.misalign", misalign_o, 0);
    rst_i = 1'b0;

    // Non-memory pass-through
    issue(32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5);
    check("alu.wb_valid", wb_valid_o, 1);
    check("alu.wb_we",    wb_we_o, 1);
    check("alu.wb_rd",    wb_rd_o, 5);
    check("alu.wb_data",  wb_data_o, 32'h0000_1234);
    check("alu.req",      dmem_req_o, 0);
    @(negedge clk_i);
    check("alu.pulse",    wb_valid_o, 0);
    issue(32'hFFFF_0000, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0);
    check("alu_x0.wb_valid", wb_valid_o, 1);
    check("alu_x0.wb_we",    wb_we_o, 0);

    // Loads: byte/halfword with sign and zero extension
    mem_op("lb",  32'h101, 0, 3'b000, 1, 0, 5'd7, 2, 1, 32'h1234_80FF,
           32'h100, 4'b0010, 0, 32'hFFFF_FF80, 1);
    mem_op("lbu", 32'h101, 0, 3'b100, 1, 0, 5'd7, 0, 0, 32'h1234_80FF,
           32'h100, 4'b0010, 0, 32'h0000_0080, 1);
    mem_op("lh",  32'h102, 0, 3'b001, 1, 0, 5'd8, 0, 0, 32'h8001_7FFF,
           32'h100, 4'b1100, 0, 32'hFFFF_8001, 1);
    mem_op("lhu", 32'h102, 0, 3'b101, 1, 0, 5'd8, 1, 0, 32'h8001_7FFF,
           32'h100, 4'b1100, 0, 32'h0000_8001, 1);
    mem_op("lh0", 32'h100, 0, 3'b001, 1, 0, 5'd9, 0, 0, 32'h8001_7FFF,
           32'h100, 4'b0011, 0, 32'h0000_7FFF, 1);

    // Stores: lane replication and strobes
    mem_op("sh", 32'h102, 32'h0000_ABCD, 3'b001, 0, 1, 5'd1, 0, 2, 0,
           32'h100, 4'b1100, 32'hABCD_ABCD, 0, 0);
    mem_op("sb", 32'h103, 32'h1234_5678, 3'b000, 0, 1, 5'd1, 1, 0, 0,
           32'h100, 4'b1000, 32'h7878_7878, 0, 0);
    mem_op("sw", 32'h200, 32'hCAFE_BABE, 3'b010, 0, 1, 5'd1, 0, 0, 0,
           32'h200, 4'b1111, 32'hCAFE_BABE, 0, 0);

    // Corner cases: rd=x0, load+store flags, invalid funct3
    mem_op("lw_x0", 32'h40, 0, 3'b010, 1, 0, 5'd0, 0, 0, 32'h1122_3344,
           32'h40, 4'b1111, 0, 32'h1122_3344, 0);
    mem_op("ld_st", 32'h44, 32'hFFFF_FFFF, 3'b010, 1, 1, 5'd4, 0, 0,
           32'h5566_7788, 32'h44, 4'b1111, 0, 32'h5566_7788, 1);
    mem_op("bad_f3", 32'h48, 0, 3'b011, 1, 0, 5'd6, 0, 0, 32'h89AB_CDEF,
           32'h48, 4'b1111, 0, 32'h89AB_CDEF, 1);

    // Misaligned accesses
`ifdef LSU_MISALIGN_EXC_EN
    issue(32'h103, 32'h0, 3'b010, 1'b1, 1'b0, 5'd2);
    check("mis_lw.req",      dmem_req_o, 0);
    check("mis_lw.wb_valid", wb_valid_o, 1);
    check("mis_lw.misalign", misalign_o, 1);
    check("mis_lw.wb_we",    wb_we_o, 0);
    check("mis_lw.ready",    ex_ready_o, 1);
    @(negedge clk_i);
    check("mis_lw.pulse",    misalign_o, 0);
    check("mis_lw.req2",     dmem_req_o, 0);
    issue(32'h101, 32'h0000_BEEF, 3'b001, 1'b0, 1'b1, 5'd2);
    check("mis_sh.req",      dmem_req_o, 0);
    check("mis_sh.misalign", misalign_o, 1);
`else
    mem_op("mis_lw", 32'h103, 0, 3'b010, 1, 0, 5'd2, 0, 0, 32'hDEAD_BEEF,
           32'h100, 4'b1111, 0, 32'hDEAD_BEEF, 1);
    mem_op("mis_sh", 32'h101, 32'h0000_BEEF, 3'b001, 0, 1, 5'd2, 0, 0, 0,
           32'h100, 4'b0011, 32'hBEEF_BEEF, 0, 0);
    mem_op("mis_lh", 32'h103, 0, 3'b001, 1, 0, 5'd2, 0, 0, 32'hF00D_1234,
           32'h100, 4'b1100, 0, 32'hFFFF_F00D, 1);
`endif

    // Timeout: grant, then no response for four cycles
    issue(32'h10, 32'h0, 3'b010, 1'b1, 1'b0, 5'd3);
    check("to.req", dmem_req_o, 1);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    check("to.req_drop", dmem_req_o, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_i);
      check("to.wait_wb",  wb_valid_o, 0);
      check("to.wait_err", bus_err_o, 0);
      check("to.wait_rdy", ex_ready_o, 0);
    end
    @(negedge clk_i);
    check("to.bus_err",  bus_err_o, 1);
    check("to.wb_valid", wb_valid_o, 1);
    check("to.wb_we",    wb_we_o, 0);
    check("to.ready",    ex_ready_o, 1);
    @(negedge clk_i);
    check("to.err_pulse", bus_err_o, 0);
    check("to.ready2",    ex_ready_o, 1);

    // Response in the limit cycle wins over the timeout
    mem_op("to_edge", 32'h14, 0, 3'b010, 1, 0, 5'd3, 0, 3, 32'h0BAD_F00D,
           32'h14, 4'b1111, 0, 32'h0BAD_F00D, 1);

    // Stray response while idle
    @(negedge clk_i);
    dmem_rvalid_i = 1'b1;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check("stray.wb_valid", wb_valid_o, 0);

    // Reset during WAIT_RSP
    issue(32'h20, 32'h0, 3'b010, 1'b1, 1'b0, 5'd10);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("rst_wait.ready", ex_ready_o, 1);
    check("rst_wait.req",   dmem_req_o, 0);
    check("rst_wait.be",    dmem_be_o, 0);
    check("rst_wait.addr",  dmem_addr_o, 0);
    check("rst_wait.wb",    wb_valid_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h7777_7777;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    check("rst_wait.late_rvalid", wb_valid_o, 0);
    @(negedge clk_i);
    check("rst_wait.no_wb", wb_valid_o, 0);
    check("rst_wait.idle",  ex_ready_o, 1);

    // Reset during REQ drops the request without a clock edge
    issue(32'h24, 32'h0, 3'b010, 1'b1, 1'b0, 5'd11);
    check("rst_req.req_pre", dmem_req_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_req.req", dmem_req_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_req.req_after", dmem_req_o, 0);
    check("rst_req.wb",        wb_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_lsu_stage
`default_nettype wire
